// File: rtl/word_frame_tx_pkg.sv
// Shared types and helpers for the 9-bit parity-bus word transmitter and its receiver.
package word_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SEND,
    LAST,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int FRAME_W        = 9;

  // Even parity over the 9-bit frame: the parity bit is the XOR of the data byte.
  function automatic logic parity8(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/word_frame_tx_parity_gen9.sv
// Byte to 9-bit frame {byte, parity}; shared with the receiver's return path.
module word_frame_tx_parity_gen9
  import word_frame_tx_pkg::*;
(
  input  logic [7:0]         data,
  output logic [FRAME_W-1:0] frame
);

  // Purely combinational; the caller registers the frame.
  assign frame = {data, parity8(data)};

endmodule

// File: rtl/word_frame_tx.sv
// Sends a latched 32-bit word as four {byte, parity} frames, MSB byte first,
// stepping frames on the receiver's nxt_data index with a per-wait watchdog.
//
//  state | meaning
//  IDLE  | bus 0, waiting for start
//  REQ   | ready high, frame 0 on bus, waiting for ack
//  SEND  | frames 0..2, advance on a fresh nxt_data == idx+1
//  LAST  | frame 3 held for LAST_HOLD cycles after its first cycle
//  DONE  | one-cycle done pulse
//  ERR   | one-cycle err pulse, word discarded
module word_frame_tx
  import word_frame_tx_pkg::*;
#(
  parameter int TIMEOUT   = 256,
  parameter int LAST_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        word_in,
  input  logic               ack,
  input  logic [1:0]         nxt_data,
  output logic               ready,
  output logic [FRAME_W-1:0] out_bus_9,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int               WD_W      = $clog2(TIMEOUT);
  localparam int               HOLD_W    = $clog2(LAST_HOLD + 1);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LAST_HOLD);
  localparam logic [1:0]       LAST_IDX  = 2'(BYTES_PER_WORD - 1);

  state_t              state;
  logic [1:0]          idx;
  logic [1:0]          idx_inc;
  logic [1:0]          sel_idx;
  logic [31:0]         word;
  logic [WD_W-1:0]     wd_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [1:0]          nxt_prev;
  logic                adv;
  logic                wd_expired;
  logic [7:0]          sel_byte;
  logic [FRAME_W-1:0]  frame;

  assign idx_inc    = idx + 2'd1;
  // Edge plus exact-match: a stale 11 left on nxt_data can never skip frames.
  assign adv        = (state == SEND) && (nxt_data == idx_inc) && (nxt_prev != idx_inc);
  assign wd_expired = (wd_cnt == WD_LAST);

  // Byte for the frame loaded on the next edge: incoming word in IDLE, else next/current index.
  always_comb begin
    sel_idx  = adv ? idx_inc : idx;
    sel_byte = word_in[31:24];
    if (state != IDLE) begin
      case (sel_idx)
        2'd0:    sel_byte = word[31:24];
        2'd1:    sel_byte = word[23:16];
        2'd2:    sel_byte = word[15:8];
        default: sel_byte = word[7:0];
      endcase
    end
  end

  word_frame_tx_parity_gen9 u_parity_gen9 (
    .data  (sel_byte),
    .frame (frame)
  );

  // Main sequencer; all outputs are registered and set on the transition into each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      word      <= '0;
      wd_cnt    <= '0;
      hold_cnt  <= '0;
      nxt_prev  <= 2'b00;
      ready     <= 1'b0;
      out_bus_9 <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      nxt_prev <= nxt_data;
      case (state)
        IDLE: begin
          if (start) begin
            word      <= word_in;
            idx       <= 2'd0;
            wd_cnt    <= '0;
            state     <= REQ;
            ready     <= 1'b1;
            busy      <= 1'b1;
            out_bus_9 <= frame;
          end
        end
        REQ: begin
          if (ack) begin
            state  <= SEND;
            idx    <= 2'd0;
            wd_cnt <= '0;
          end else if (wd_expired) begin
            state     <= ERR;
            err       <= 1'b1;
            ready     <= 1'b0;
            out_bus_9 <= '0;
            word      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        SEND: begin
          if (adv) begin
            idx       <= idx_inc;
            wd_cnt    <= '0;
            out_bus_9 <= frame;
            if (idx_inc == LAST_IDX) begin
              state    <= LAST;
              hold_cnt <= '0;
            end
          end else if (wd_expired) begin
            state     <= ERR;
            err       <= 1'b1;
            ready     <= 1'b0;
            out_bus_9 <= '0;
            word      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        LAST: begin
          // Frame 3 is visible for its first cycle plus LAST_HOLD more.
          if (hold_cnt == HOLD_LAST) begin
            state     <= DONE;
            done      <= 1'b1;
            ready     <= 1'b0;
            out_bus_9 <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          ready     <= 1'b0;
          busy      <= 1'b0;
          out_bus_9 <= '0;
        end
      endcase
    end
  end

endmodule
